dac_serializer: RTL and testbench

Codec-side DAC transmitter for the audio path. It accepts stereo sample pairs from the looper/filter logic through the `write`/`write_ready` handshake and buffers them in a small FIFO. It then serializes them onto `AUD_DACDAT` in I2S format, timed by the codec-mastered `AUD_BCLK` and `AUD_DACLRCK`. It sits between the sample-producing logic and the codec pins, replacing the DAC half of the vendor codec core.

---
 rtl/dac_serializer.sv | 148 ++++++++++++++
 tb/tb_dac_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serializer.sv
// I2S DAC transmitter: buffers stereo pairs in a small FIFO and shifts them out
// on the codec-mastered BCLK/LRCK, both synchronized into the clk domain.
module dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic signed [DATA_WIDTH-1:0]  writedata_left,
  input  logic signed [DATA_WIDTH-1:0]  writedata_right,
  output logic                          write_ready,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] NBITS = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {SYNC = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

  logic [2:0]              bclk_sync_q, bclk_sync_d;
  logic [2:0]              lrck_sync_q, lrck_sync_d;
  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d, hold_q, hold_d;
  logic [BW-1:0]           bitcnt_q, bitcnt_d;
  logic                    delay_q, delay_d;
  logic                    dacdat_q, dacdat_d;
  logic                    underflow_q, underflow_d;
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic bclk_fall, lrck_fall, lrck_rise;
  logic push, pop, frame_start, half_start;

  // [0],[1] are the synchronizer stages, [2] the edge-detect delay
  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];
  assign lrck_rise = ~lrck_sync_q[2] & lrck_sync_q[1];

  assign write_ready = (cnt_q != FULL);
  assign fill        = cnt_q;
  assign AUD_DACDAT  = dacdat_q;
  assign underflow   = underflow_q;

  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[1:0], AUD_DACLRCK};
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    bitcnt_d    = bitcnt_q;
    delay_d     = delay_q;
    dacdat_d    = dacdat_q;
    underflow_d = underflow_q;

    push        = write && (cnt_q != FULL);
    frame_start = lrck_fall && (state_q != LEFT);
    pop         = frame_start && (cnt_q != '0);
    half_start  = frame_start || (lrck_rise && (state_q == LEFT));

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;

    if (frame_start) begin
      state_d = LEFT;
      if (pop) begin
        {shreg_d, hold_d} = mem_q[rd_ptr_q];
      end else begin
        shreg_d     = '0;
        hold_d      = '0;
        underflow_d = 1'b1;
      end
    end else if (lrck_rise && (state_q == LEFT)) begin
      state_d = RIGHT;
      shreg_d = hold_q;
    end

    // An LRCK edge wins over a coincident BCLK fall, which becomes the delay bit
    if (half_start) begin
      bitcnt_d = '0;
      if (bclk_fall) begin
        dacdat_d = 1'b0;
        delay_d  = 1'b0;
      end else begin
        delay_d  = 1'b1;
      end
    end else if ((state_q != SYNC) && bclk_fall) begin
      if (delay_q) begin
        dacdat_d = 1'b0;
        delay_d  = 1'b0;
      end else if (bitcnt_q < NBITS) begin
        dacdat_d = shreg_q[DATA_WIDTH-1];
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + 1'b1;
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      state_q     <= SYNC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      delay_q     <= 1'b0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      delay_q     <= delay_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {writedata_left, writedata_right};
  end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: drives BCLK/LRCK as the codec would and decodes
// AUD_DACDAT at BCLK rising edges against a queue-based model of the sample stream.
module tb_dac_serializer;
  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int HALF  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic [DW-1:0] wl = '0, wr = '0;
  logic          write_ready;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DACLRCK = 1'b1;
  logic          AUD_DACDAT;
  logic [2:0]    fill;
  logic          underflow;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [47:0]   mq[$];
  logic          exp_uf = 1'b0;

  typedef struct {
    logic [31:0] gl, el, gr, er;
    logic [2:0]  fo;
    int          fe;
    logic        ro;
    logic        uo;
  } frame_res_t;

  dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write(write),
    .writedata_left(wl), .writedata_right(wr), .write_ready(write_ready),
    .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .fill(fill), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Expected half-frame as seen at BCLK rises: delay slot, word MSB-first, zero pad
  function automatic logic [31:0] exp_half(input logic [DW-1:0] word, input int nbits);
    logic [31:0] e = '0;
    for (int k = 0; k < nbits; k++)
      e = {e[30:0], (k >= 1 && k <= DW) ? word[DW-k] : 1'b0};
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; write = 1'b0; AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b1;
    mq.delete(); exp_uf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_pair(input logic [47:0] p);
    @(negedge clk);
    write = 1'b1; {wl, wr} = p;
    @(negedge clk);
    write = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(p);
  endtask

  task automatic half_frame(input logic lr, input int lead, input int nbits, output logic [31:0] got);
    @(negedge clk);
    AUD_DACLRCK = lr;
    repeat (lead) @(negedge clk);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      AUD_BCLK = 1'b0;
      repeat (HALF) @(negedge clk);
      got = {got[30:0], AUD_DACDAT};
      AUD_BCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  // One stereo frame; an optional push lands in the same clk cycle as the frame-start pop
  task automatic do_frame(input int lead, input int lbits, input bit do_push,
                          input logic [47:0] pd, output frame_res_t r);
    int          pre;
    bit          acc;
    logic [47:0] ep;
    logic [31:0] gl, gr;
    pre = mq.size();
    acc = do_push && (pre < DEPTH);
    if (pre > 0) ep = mq.pop_front();
    else begin
      ep = '0;
      exp_uf = 1'b1;
    end
    if (acc) mq.push_back(pd);
    r.fe = mq.size();
    fork
      half_frame(1'b0, lead, lbits, gl);
      begin
        repeat (3) @(negedge clk);
        if (do_push) begin
          write = 1'b1; {wl, wr} = pd;
        end
        @(negedge clk);
        write = 1'b0;
        r.fo = fill;
        r.ro = write_ready;
      end
    join
    half_frame(1'b1, 0, 32, gr);
    r.gl = gl; r.el = exp_half(ep[47:24], lbits);
    r.gr = gr; r.er = exp_half(ep[23:0], 32);
    r.uo = underflow;
  endtask

  task automatic test_reset();
    frame_res_t r;
    apply_reset();
    n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", write_ready); end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("FAIL rst_fill: got %0d want 0", fill); end
    n_cmp++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL rst_dacdat: got %b want 0", AUD_DACDAT); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %b want 0", underflow); end
    do_frame(0, 32, 1'b0, '0, r);
    n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL rst_left: got %h want %h", r.gl, r.el); end
    n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL rst_right: got %h want %h", r.gr, r.er); end
    n_cmp++; if (r.uo !== exp_uf) begin n_err++; $display("FAIL rst_uflow_set: got %b want %b", r.uo, exp_uf); end
  endtask

  task automatic test_single();
    frame_res_t r;
    apply_reset();
    push_pair({24'hA5A5A5, 24'h3C3C3C});
    do_frame(0, 32, 1'b0, '0, r);
    n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL single_left: got %h want %h", r.gl, r.el); end
    n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL single_right: got %h want %h", r.gr, r.er); end
    n_cmp++; if (r.uo !== exp_uf) begin n_err++; $display("FAIL single_uflow: got %b want %b", r.uo, exp_uf); end
    // LRCK moving a few clk ahead of the BCLK fall still yields exactly one delay slot
    push_pair({24'h800001, 24'h7FFFFE});
    do_frame(3, 32, 1'b0, '0, r);
    n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL lead_left: got %h want %h", r.gl, r.el); end
    n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL lead_right: got %h want %h", r.gr, r.er); end
  endtask

  task automatic test_full();
    frame_res_t r;
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_pair({$urandom_range(24'hFFFFFF, 0), $urandom_range(24'hFFFFFF, 0)});
      n_cmp++; if (fill !== 3'(mq.size())) begin n_err++; $display("FAIL full_fill%0d: got %0d want %0d", i, fill, mq.size()); end
      n_cmp++; if (write_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL full_ready%0d: got %b want %b", i, write_ready, mq.size() < DEPTH); end
    end
    for (int f = 0; f < DEPTH + 1; f++) begin
      do_frame(0, 32, 1'b0, '0, r);
      n_cmp++; if (r.fo !== 3'(r.fe)) begin n_err++; $display("FAIL drain_fill%0d: got %0d want %0d", f, r.fo, r.fe); end
      n_cmp++; if (r.ro !== (r.fe < DEPTH)) begin n_err++; $display("FAIL drain_ready%0d: got %b want %b", f, r.ro, r.fe < DEPTH); end
      n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL drain_left%0d: got %h want %h", f, r.gl, r.el); end
      n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL drain_right%0d: got %h want %h", f, r.gr, r.er); end
      n_cmp++; if (r.uo !== exp_uf) begin n_err++; $display("FAIL drain_uflow%0d: got %b want %b", f, r.uo, exp_uf); end
    end
  endtask

  task automatic test_back_to_back();
    frame_res_t r;
    apply_reset();
    push_pair({$urandom_range(24'hFFFFFF, 0), $urandom_range(24'hFFFFFF, 0)});
    push_pair({$urandom_range(24'hFFFFFF, 0), $urandom_range(24'hFFFFFF, 0)});
    for (int f = 0; f < 10; f++) begin
      do_frame(0, 32, 1'b1, {$urandom_range(24'hFFFFFF, 0), $urandom_range(24'hFFFFFF, 0)}, r);
      n_cmp++; if (r.fo !== 3'd2) begin n_err++; $display("FAIL b2b_fill%0d: got %0d want 2", f, r.fo); end
      n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL b2b_left%0d: got %h want %h", f, r.gl, r.el); end
      n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL b2b_right%0d: got %h want %h", f, r.gr, r.er); end
    end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL b2b_uflow: got %b want 0", underflow); end
  endtask

  task automatic test_random();
    frame_res_t r;
    apply_reset();
    for (int f = 0; f < 12; f++) begin
      do_frame($urandom_range(3, 0), $urandom_range(32, 12), ($urandom_range(9, 0) < 7),
               {$urandom_range(24'hFFFFFF, 0), $urandom_range(24'hFFFFFF, 0)}, r);
      n_cmp++; if (r.fo !== 3'(r.fe)) begin n_err++; $display("FAIL rnd_fill%0d: got %0d want %0d", f, r.fo, r.fe); end
      n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL rnd_left%0d: got %h want %h", f, r.gl, r.el); end
      n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL rnd_right%0d: got %h want %h", f, r.gr, r.er); end
      n_cmp++; if (r.uo !== exp_uf) begin n_err++; $display("FAIL rnd_uflow%0d: got %b want %b", f, r.uo, exp_uf); end
    end
  endtask

  task automatic test_mid_reset();
    frame_res_t  r;
    logic [31:0] g;
    logic [47:0] p3;
    apply_reset();
    push_pair({24'hFFFFFF, 24'h123456});
    push_pair({24'h0F0F0F, 24'h654321});
    @(negedge clk);
    AUD_DACLRCK = 1'b0;
    for (int i = 0; i < 12; i++) begin
      AUD_BCLK = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 11) begin
        AUD_BCLK = 1'b1;
        repeat (HALF) @(negedge clk);
      end
    end
    n_cmp++; if (AUD_DACDAT !== 1'b1) begin n_err++; $display("FAIL mr_before: got %b want 1", AUD_DACDAT); end
    reset = 1'b1;
    #1;
    n_cmp++; if (AUD_DACDAT !== 1'b0) begin n_err++; $display("FAIL mr_dacdat: got %b want 0", AUD_DACDAT); end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("FAIL mr_fill: got %0d want 0", fill); end
    n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %b want 1", write_ready); end
    mq.delete(); exp_uf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    AUD_BCLK = 1'b1;
    repeat (HALF) @(negedge clk);
    g = '0;
    for (int i = 12; i < 32; i++) begin
      AUD_BCLK = 1'b0;
      repeat (HALF) @(negedge clk);
      g = {g[30:0], AUD_DACDAT};
      AUD_BCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    n_cmp++; if (g !== 32'd0) begin n_err++; $display("FAIL mr_rest_left: got %h want 0", g); end
    half_frame(1'b1, 0, 32, g);
    n_cmp++; if (g !== 32'd0) begin n_err++; $display("FAIL mr_sync_right: got %h want 0", g); end
    p3 = {$urandom_range(24'hFFFFFF, 0), $urandom_range(24'hFFFFFF, 0)};
    push_pair(p3);
    do_frame(0, 32, 1'b0, '0, r);
    n_cmp++; if (r.gl !== r.el) begin n_err++; $display("FAIL mr_next_left: got %h want %h", r.gl, r.el); end
    n_cmp++; if (r.gr !== r.er) begin n_err++; $display("FAIL mr_next_right: got %h want %h", r.gr, r.er); end
    n_cmp++; if (r.uo !== 1'b0) begin n_err++; $display("FAIL mr_uflow: got %b want 0", r.uo); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
